// File: rtl/axis_pkg.sv
// Shared definitions for the AXI4-Stream transmit/receive FIFOs.
// Holds the default stream geometry, the packed beat layout {user, last, data},
// and helpers that derive the beat and byte-strobe widths from a data width.
package axis_pkg;

  localparam int AXIS_TDATA_WIDTH = 32;
  localparam int AXIS_FIFO_DEPTH  = 16;
  localparam int AXIS_TSTRB_WIDTH = AXIS_TDATA_WIDTH / 8;

  // Every byte of every beat is meaningful, so TSTRB is constant all ones.
  localparam logic [AXIS_TSTRB_WIDTH-1:0] AXIS_TSTRB_ALL = '1;

  typedef struct packed {
    logic                        user;
    logic                        last;
    logic [AXIS_TDATA_WIDTH-1:0] data;
  } axis_beat_t;

  // Storage width of one beat: data plus the two sideband bits.
  function automatic int axis_beat_width(input int data_w);
    return data_w + 2;
  endfunction

  function automatic int axis_strb_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Simple dual-port storage for stream FIFOs.
// Ports:
//   clk      - write clock (rising edge)
//   wr_en    - write strobe; wr_data lands at mem[wr_addr] on the edge
//   wr_addr  - write address
//   wr_data  - beat to store
//   rd_addr  - read address
//   rd_data  - asynchronous read of mem[rd_addr]
// No reset: contents are meaningless until written, and the owning FIFO's
// pointers decide which entries are live.
module axis_fifo_mem #(
  parameter int DATA_W = 34,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/m00_axis_tx.sv
// AXI4-Stream master-side transmit FIFO for the crop-video datapath.
// Upstream pushes {user_in, last_in, data_in} with wr_en; beats are buffered in
// a DEPTH-entry memory and presented through one registered output stage.
// Ports:
//   M_AXIS_ACLK / M_AXIS_ARESETN - clock, synchronous active-low reset
//   wr_en, data_in, user_in, last_in - push interface
//   full, empty, count, wr_err       - status (count excludes the output register)
//   M_AXIS_T*                        - AXI4-Stream master port
module m00_axis_tx
  import axis_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = AXIS_TDATA_WIDTH,
  parameter int C_M_AXIS_FIFO_DEPTH  = AXIS_FIFO_DEPTH
) (
  input  logic                                  M_AXIS_ACLK,
  input  logic                                  M_AXIS_ARESETN,
  input  logic                                  wr_en,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]       data_in,
  input  logic                                  user_in,
  input  logic                                  last_in,
  output logic                                  full,
  output logic                                  empty,
  output logic [$clog2(C_M_AXIS_FIFO_DEPTH):0]  count,
  output logic                                  wr_err,
  output logic                                  M_AXIS_TVALID,
  input  logic                                  M_AXIS_TREADY,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]       M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]     M_AXIS_TSTRB,
  output logic                                  M_AXIS_TUSER,
  output logic                                  M_AXIS_TLAST
);

  localparam int DW = C_M_AXIS_TDATA_WIDTH;
  localparam int AW = $clog2(C_M_AXIS_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = axis_beat_width(DW);
  localparam int SW = axis_strb_width(DW);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          tvalid_q;
  logic [DW-1:0] tdata_q;
  logic          tuser_q;
  logic          tlast_q;
  logic          wr_err_q;
  logic [BW-1:0] rd_beat;
  logic          push;
  logic          pop;

  // full comes from the registered count, so a pop in the same cycle cannot
  // make room for a push that arrives while full.
  assign full  = (count_q == CW'(C_M_AXIS_FIFO_DEPTH));
  assign empty = (count_q == '0) && !tvalid_q;
  assign push  = wr_en && !full;
  // Refill the output register whenever it is empty or being drained.
  assign pop   = (count_q != '0) && (!tvalid_q || M_AXIS_TREADY);

  axis_fifo_mem #(
    .DATA_W (BW),
    .DEPTH  (C_M_AXIS_FIFO_DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (M_AXIS_ACLK),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data ({user_in, last_in, data_in}),
    .rd_addr (rd_ptr),
    .rd_data (rd_beat)
  );

  always_ff @(posedge M_AXIS_ACLK) begin
    if (!M_AXIS_ARESETN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      wr_err_q <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      wr_err_q <= wr_en && full;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
      if (pop) begin
        tvalid_q <= 1'b1;
        tuser_q  <= rd_beat[BW-1];
        tlast_q  <= rd_beat[BW-2];
        tdata_q  <= rd_beat[DW-1:0];
      end else if (M_AXIS_TREADY) begin
        // Handshake with nothing queued behind it; data is left as-is.
        tvalid_q <= 1'b0;
      end
    end
  end

  assign count         = count_q;
  assign wr_err        = wr_err_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TUSER  = tuser_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign M_AXIS_TSTRB  = {SW{1'b1}};

endmodule
